rob_commit_ctrl: RTL and testbench

In-order reorder-buffer controller that owns the register file's write port. It allocates RSV IDs to dispatched instructions, records out-of-order completions, and retires entries in program order by driving the register file commit interface (we/wrQueAddr/wrAddr/wrData). On retirement of a mispredicted branch it pulses pred_miss and flushes all younger entries.

---
 rtl/rob_commit_ctrl.sv | 120 ++++++++++++
 tb/tb_rob_commit_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_ctrl.sv
// In-order reorder-buffer controller: allocates IDs at dispatch, records out-of-order
// completions and retires the head entry through the register-file write port.
module rob_commit_ctrl #(
    parameter int RSV_ID_W   = 4,
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_req,
    input  logic [REG_ADDR_W-1:0] alloc_dst,
    output logic                  alloc_gnt,
    output logic [RSV_ID_W-1:0]   alloc_id,
    input  logic                  cmpl_valid,
    input  logic [RSV_ID_W-1:0]   cmpl_id,
    input  logic [DATA_W-1:0]     cmpl_data,
    input  logic                  cmpl_miss,
    output logic                  rf_we,
    output logic [RSV_ID_W-1:0]   rf_que_addr,
    output logic [REG_ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0]     rf_data,
    output logic                  pred_miss,
    output logic [RSV_ID_W:0]     count,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 1 << RSV_ID_W;
    localparam logic [RSV_ID_W:0] FULL_CNT = (RSV_ID_W + 1)'(DEPTH);

    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      done_q;
    logic [DEPTH-1:0]      miss_q;
    logic [REG_ADDR_W-1:0] dst_q  [DEPTH];
    logic [DATA_W-1:0]     data_q [DEPTH];
    logic [RSV_ID_W-1:0]   head_q;
    logic [RSV_ID_W-1:0]   tail_q;
    logic [RSV_ID_W:0]     count_q;

    logic commit_now;
    logic flush_now;
    logic alloc_fire;
    logic cmpl_fire;

    assign commit_now = valid_q[head_q] && done_q[head_q];
    assign flush_now  = commit_now && miss_q[head_q];
    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign alloc_id   = tail_q;
    // No same-cycle bypass: a full buffer refuses even while retiring its head.
    assign alloc_gnt  = !rst && !full && !flush_now;
    assign alloc_fire = alloc_req && alloc_gnt;
    assign cmpl_fire  = cmpl_valid && valid_q[cmpl_id] && !done_q[cmpl_id] && !flush_now;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            done_q  <= '0;
            miss_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_now) begin
            valid_q <= '0;
            done_q  <= '0;
            miss_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (alloc_fire) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
                miss_q[tail_q]  <= 1'b0;
                tail_q          <= tail_q + 1'b1;
            end
            if (cmpl_fire) begin
                done_q[cmpl_id] <= 1'b1;
                miss_q[cmpl_id] <= cmpl_miss;
            end
            if (commit_now) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (alloc_fire && !commit_now) begin
                count_q <= count_q + 1'b1;
            end else if (!alloc_fire && commit_now) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Payload storage carries no reset; the flags decide whether it is meaningful.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            dst_q[tail_q] <= alloc_dst;
        end
        if (cmpl_fire) begin
            data_q[cmpl_id] <= cmpl_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we       <= 1'b0;
            rf_que_addr <= '0;
            rf_addr     <= '0;
            rf_data     <= '0;
            pred_miss   <= 1'b0;
        end else begin
            rf_we     <= commit_now;
            pred_miss <= flush_now;
            if (commit_now) begin
                rf_que_addr <= head_q;
                rf_addr     <= dst_q[head_q];
                rf_data     <= data_q[head_q];
            end
        end
    end
endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Self-checking bench for rob_commit_ctrl: a program-order queue model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_rob_commit_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alloc_req = 1'b0;
    logic [4:0]  alloc_dst = '0;
    logic        alloc_gnt;
    logic [3:0]  alloc_id;
    logic        cmpl_valid = 1'b0;
    logic [3:0]  cmpl_id = '0;
    logic [31:0] cmpl_data = '0;
    logic        cmpl_miss = 1'b0;
    logic        rf_we;
    logic [3:0]  rf_que_addr;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        pred_miss;
    logic [4:0]  count;
    logic        full;
    logic        empty;

    int total = 0;
    int bad   = 0;
    bit checkEn = 1'b0;

    rob_commit_ctrl #(.RSV_ID_W(4), .REG_ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .alloc_dst(alloc_dst), .alloc_gnt(alloc_gnt), .alloc_id(alloc_id),
        .cmpl_valid(cmpl_valid), .cmpl_id(cmpl_id), .cmpl_data(cmpl_data), .cmpl_miss(cmpl_miss),
        .rf_we(rf_we), .rf_que_addr(rf_que_addr), .rf_addr(rf_addr), .rf_data(rf_data),
        .pred_miss(pred_miss), .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  id;
        logic [4:0]  dst;
        bit          done;
        bit          miss;
        logic [31:0] data;
    } ent_t;

    // Model: live instructions in program order; the front is the oldest.
    ent_t        mq[$];
    logic [3:0]  mNextId = '0;
    bit          mWe = 1'b0;
    bit          mPm = 1'b0;
    logic [3:0]  mQue = '0;
    logic [4:0]  mAddr = '0;
    logic [31:0] mData = '0;

    function automatic bit modelFlushNow();
        return (mq.size() > 0) && mq[0].done && mq[0].miss;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mNextId = '0;
            mWe = 1'b0; mPm = 1'b0; mQue = '0; mAddr = '0; mData = '0;
        end else begin
            bit   doCommit;
            bit   doFlush;
            bit   grant;
            ent_t e;
            doCommit = (mq.size() > 0) && mq[0].done;
            doFlush  = modelFlushNow();
            grant    = (mq.size() < 16) && !doFlush;
            mWe = doCommit;
            mPm = doFlush;
            if (doCommit) begin
                mQue = mq[0].id; mAddr = mq[0].dst; mData = mq[0].data;
            end
            if (doFlush) begin
                mq.delete();
                mNextId = '0;
            end else begin
                if (cmpl_valid) begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (mq[i].id == cmpl_id && !mq[i].done) begin
                            e = mq[i];
                            e.done = 1'b1; e.miss = cmpl_miss; e.data = cmpl_data;
                            mq[i] = e;
                        end
                    end
                end
                if (doCommit) void'(mq.pop_front());
                if (alloc_req && grant) begin
                    e.id = mNextId; e.dst = alloc_dst; e.done = 1'b0; e.miss = 1'b0; e.data = '0;
                    mq.push_back(e);
                    mNextId = mNextId + 4'd1;
                end
            end
        end
    end

    task automatic doCheck(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        doCheck("m_rf_we", 64'(rf_we), 64'(mWe));
        doCheck("m_pred_miss", 64'(pred_miss), 64'(mPm));
        doCheck("m_count", 64'(count), 64'(mq.size()));
        doCheck("m_full", 64'(full), 64'(mq.size() == 16));
        doCheck("m_empty", 64'(empty), 64'(mq.size() == 0));
        doCheck("m_alloc_id", 64'(alloc_id), 64'(mNextId));
        doCheck("m_alloc_gnt", 64'(alloc_gnt), 64'(!rst && mq.size() < 16 && !modelFlushNow()));
        if (mWe) begin
            doCheck("m_rf_que_addr", 64'(rf_que_addr), 64'(mQue));
            doCheck("m_rf_addr", 64'(rf_addr), 64'(mAddr));
            doCheck("m_rf_data", 64'(rf_data), 64'(mData));
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) checkOutput();
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_req = 1'b0; cmpl_valid = 1'b0; cmpl_miss = 1'b0;
    endtask

    task automatic doReset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic alloc(input logic [4:0] dst);
        alloc_req = 1'b1; alloc_dst = dst;
        tick();
        alloc_req = 1'b0;
    endtask

    task automatic cmpl(input logic [3:0] id, input logic [31:0] data, input logic miss);
        cmpl_valid = 1'b1; cmpl_id = id; cmpl_data = data; cmpl_miss = miss;
        tick();
        cmpl_valid = 1'b0; cmpl_miss = 1'b0;
    endtask

    task automatic expCommit(input string name, input logic we, input logic [3:0] que,
                             input logic [4:0] addr, input logic [31:0] data);
        doCheck({name, "_we"}, 64'(rf_we), 64'(we));
        if (we) begin
            doCheck({name, "_que"}, 64'(rf_que_addr), 64'(que));
            doCheck({name, "_addr"}, 64'(rf_addr), 64'(addr));
            doCheck({name, "_data"}, 64'(rf_data), 64'(data));
        end
    endtask

    task automatic applyStimulus();
        // Reset asserted between edges must act immediately.
        #1 rst = 1'b1;
        #1;
        doCheck("t1_rf_we", 64'(rf_we), 64'd0);
        doCheck("t1_pred_miss", 64'(pred_miss), 64'd0);
        doCheck("t1_empty", 64'(empty), 64'd1);
        doCheck("t1_count", 64'(count), 64'd0);
        doCheck("t1_alloc_id", 64'(alloc_id), 64'd0);
        doCheck("t1_alloc_gnt", 64'(alloc_gnt), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        checkEn = 1'b1;

        // Out-of-order completion, in-order retirement.
        alloc(5'd5); alloc(5'd6); alloc(5'd7);
        doCheck("t2_count", 64'(count), 64'd3);
        cmpl(4'd2, 32'hC, 1'b0);
        expCommit("t2_c0", 1'b0, 4'd0, 5'd0, 32'd0);
        cmpl(4'd0, 32'hA, 1'b0);
        expCommit("t2_c1", 1'b0, 4'd0, 5'd0, 32'd0);
        cmpl(4'd1, 32'hB, 1'b0);
        expCommit("t2_c2", 1'b1, 4'd0, 5'd5, 32'hA);
        tick();
        expCommit("t2_c3", 1'b1, 4'd1, 5'd6, 32'hB);
        tick();
        expCommit("t2_c4", 1'b1, 4'd2, 5'd7, 32'hC);
        tick();
        expCommit("t2_c5", 1'b0, 4'd0, 5'd0, 32'd0);
        doCheck("t2_empty", 64'(empty), 64'd1);

        // Fill to capacity, then wrap the tail.
        doReset();
        for (int i = 0; i < 16; i++) alloc(5'(i + 8));
        alloc_req = 1'b1; alloc_dst = 5'd30;
        #1;
        doCheck("t3_full", 64'(full), 64'd1);
        doCheck("t3_count", 64'(count), 64'd16);
        doCheck("t3_gnt_full", 64'(alloc_gnt), 64'd0);
        alloc_req = 1'b0;
        cmpl(4'd0, 32'h100, 1'b0);
        doCheck("t3_gnt_pending", 64'(alloc_gnt), 64'd0);
        tick();
        expCommit("t3_commit", 1'b1, 4'd0, 5'd8, 32'h100);
        doCheck("t3_gnt_after", 64'(alloc_gnt), 64'd1);
        doCheck("t3_alloc_id_wrap", 64'(alloc_id), 64'd0);
        alloc(5'd20);
        doCheck("t3_count_refill", 64'(count), 64'd16);

        // Mispredict flush.
        doReset();
        alloc(5'd1); alloc(5'd2); alloc(5'd3); alloc(5'd4);
        cmpl(4'd2, 32'h22, 1'b0);
        cmpl(4'd3, 32'h33, 1'b0);
        cmpl(4'd1, 32'h11, 1'b1);
        cmpl(4'd0, 32'hA0, 1'b0);
        expCommit("t4_c0", 1'b0, 4'd0, 5'd0, 32'd0);
        tick();
        expCommit("t4_c1", 1'b1, 4'd0, 5'd1, 32'hA0);
        doCheck("t4_pm0", 64'(pred_miss), 64'd0);
        alloc_req = 1'b1; alloc_dst = 5'd9;
        #1;
        doCheck("t4_gnt_flush", 64'(alloc_gnt), 64'd0);
        tick();
        alloc_req = 1'b0;
        expCommit("t4_c2", 1'b1, 4'd1, 5'd2, 32'h11);
        doCheck("t4_pm1", 64'(pred_miss), 64'd1);
        doCheck("t4_count", 64'(count), 64'd0);
        doCheck("t4_alloc_id", 64'(alloc_id), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expCommit("t4_quiet", 1'b0, 4'd0, 5'd0, 32'd0);
            doCheck("t4_pm_quiet", 64'(pred_miss), 64'd0);
        end

        // Reset while live entries are retiring.
        doReset();
        for (int i = 0; i < 5; i++) alloc(5'(i + 1));
        cmpl(4'd0, 32'h50, 1'b0);
        cmpl(4'd1, 32'h51, 1'b0);
        expCommit("t5_pre", 1'b1, 4'd0, 5'd1, 32'h50);
        rst = 1'b1;
        #1;
        doCheck("t5_rf_we", 64'(rf_we), 64'd0);
        doCheck("t5_count", 64'(count), 64'd0);
        tick();
        rst = 1'b0;
        doCheck("t5_alloc_id", 64'(alloc_id), 64'd0);
        alloc(5'd12);
        doCheck("t5_count_after", 64'(count), 64'd1);

        // Ignored completions: unallocated id and duplicate completion.
        doReset();
        alloc(5'd3); alloc(5'd4);
        cmpl(4'd9, 32'hDEAD, 1'b0);
        expCommit("t6_c0", 1'b0, 4'd0, 5'd0, 32'd0);
        cmpl(4'd1, 32'h55, 1'b0);
        cmpl(4'd1, 32'h66, 1'b1);
        expCommit("t6_c1", 1'b0, 4'd0, 5'd0, 32'd0);
        doCheck("t6_count", 64'(count), 64'd2);
        cmpl(4'd0, 32'h44, 1'b0);
        tick();
        expCommit("t6_c2", 1'b1, 4'd0, 5'd3, 32'h44);
        tick();
        expCommit("t6_c3", 1'b1, 4'd1, 5'd4, 32'h55);
        doCheck("t6_pm", 64'(pred_miss), 64'd0);
        tick();
        doCheck("t6_empty", 64'(empty), 64'd1);
        tick();
    endtask

    initial begin
        applyStimulus();
        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
